// File: rtl/pattern_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// led_display_package
//   Shared types for the LED display path: the row type carried between the
//   pattern generators and the display driver, and the pattern sequencer
//   state encoding.
//
//   GL_NUM_COL_PIXELS  number of pixels in one display row
//   rgb_row_t          one row of pixels, each pixel {b,g,r}
//   seq_state_t        pattern sequencer states
//   next_colour()      colour step used when the pattern list wraps;
//                      cycles 1..7 and never yields black
// ---------------------------------------------------------------------------
package led_display_package;

    localparam int GL_NUM_COL_PIXELS = 8;

    typedef logic [GL_NUM_COL_PIXELS-1:0][2:0] rgb_row_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_BLANK
    } seq_state_t;

    function automatic logic [2:0] next_colour(input logic [2:0] colour);
        return (colour == 3'd7) ? 3'd1 : colour + 3'd1;
    endfunction

endpackage

// File: rtl/pattern_sequencer_frame_counter.sv
// ---------------------------------------------------------------------------
// frame_counter
//   Counts frame ticks up to a terminal value and holds there. Used by the
//   sequencer both for the dwell period and for the blank gap; the caller
//   picks the terminal value for the current phase.
//
//   clk          system clock
//   rst          asynchronous reset, active-high (count -> 0)
//   clear        synchronous clear, wins over tick
//   tick         count one frame
//   terminal     terminal count for the current phase
//   at_terminal  count == terminal
// ---------------------------------------------------------------------------
module frame_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         tick,
    input  logic [W-1:0] terminal,
    output logic         at_terminal
);

    logic [W-1:0] count;

    assign at_terminal = (count == terminal);

    // Saturates at the terminal value so a long manual dwell cannot wrap
    // the counter back through zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && !at_terminal) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pattern_sequencer.sv
// ---------------------------------------------------------------------------
// pattern_sequencer
//   Schedules several pattern generators onto the single row datapath that
//   feeds the display driver. One source is shown at a time for a number of
//   frames, optional blank frames separate patterns, the incoming generator
//   is restarted, and the colour handed to all generators steps each time the
//   pattern list wraps.
//
//   clk_in               system clock
//   reset_in             asynchronous reset, active-high
//   enable_in            1 = sequence runs, 0 = display blanked (IDLE)
//   auto_in              1 = advance when the dwell expires
//   pause_in             freeze frame counting
//   next_in              1-cycle pulse: advance now (ignored while blanking)
//   frame_done_in        1-cycle pulse from the driver at each frame end
//   pattern_rows_in      current row from each pattern source
//   colour_out           colour for all generators, {b,g,r}
//   pattern_sel_out      index of the active pattern
//   pattern_restart_out  one-hot 1-cycle restart for the incoming generator
//   row_out              registered row to the display driver
// ---------------------------------------------------------------------------
module pattern_sequencer
    import led_display_package::*;
#(
    parameter int NUM_PATTERNS = 4,
    parameter int DWELL_FRAMES = 600,
    parameter int BLANK_FRAMES = 8,
    localparam int SEL_W = $clog2(NUM_PATTERNS)
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    enable_in,
    input  logic                    auto_in,
    input  logic                    pause_in,
    input  logic                    next_in,
    input  logic                    frame_done_in,
    input  rgb_row_t                pattern_rows_in [NUM_PATTERNS],
    output logic [2:0]              colour_out,
    output logic [SEL_W-1:0]        pattern_sel_out,
    output logic [NUM_PATTERNS-1:0] pattern_restart_out,
    output rgb_row_t                row_out
);

    localparam int CNT_MAX = (DWELL_FRAMES > BLANK_FRAMES) ? DWELL_FRAMES : BLANK_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam bit HAS_BLANK = (BLANK_FRAMES > 0);

    localparam logic [CNT_W-1:0] DWELL_TERM = CNT_W'(DWELL_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLANK_TERM = HAS_BLANK ? CNT_W'(BLANK_FRAMES - 1) : '0;

    localparam logic [SEL_W-1:0]        LAST_SEL  = SEL_W'(NUM_PATTERNS - 1);
    localparam logic [NUM_PATTERNS-1:0] FIRST_ONE = NUM_PATTERNS'(1);

    seq_state_t              state, state_n;
    logic [SEL_W-1:0]        sel_n;
    logic [2:0]              colour_n;
    logic [NUM_PATTERNS-1:0] restart_n;
    rgb_row_t                row_n;

    logic             frame;       // a frame that counts (not paused)
    logic             cnt_clear;
    logic             cnt_tick;
    logic             at_term;
    logic [CNT_W-1:0] cnt_terminal;
    logic             advance;     // step to the next pattern this cycle
    logic             start;       // IDLE -> RUN entry

    assign cnt_terminal = (state == SEQ_BLANK) ? BLANK_TERM : DWELL_TERM;

    frame_counter #(
        .W (CNT_W)
    ) u_frame_counter (
        .clk         (clk_in),
        .rst         (reset_in),
        .clear       (cnt_clear),
        .tick        (cnt_tick),
        .terminal    (cnt_terminal),
        .at_terminal (at_term)
    );

    always_comb begin
        frame     = frame_done_in & ~pause_in;
        state_n   = state;
        cnt_clear = 1'b0;
        cnt_tick  = 1'b0;
        advance   = 1'b0;
        start     = 1'b0;

        if (!enable_in) begin
            // Disable overrides every other event; position is kept.
            state_n   = SEQ_IDLE;
            cnt_clear = 1'b1;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    state_n   = SEQ_RUN;
                    cnt_clear = 1'b1;
                    start     = 1'b1;
                end
                SEQ_RUN: begin
                    cnt_tick = frame;
                    // next_in and dwell expiry in the same cycle collapse
                    // into a single exit, hence a single advance.
                    if ((auto_in & frame & at_term) | next_in) begin
                        cnt_clear = 1'b1;
                        if (HAS_BLANK) begin
                            state_n = SEQ_BLANK;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
                SEQ_BLANK: begin
                    cnt_tick = frame;
                    if (frame & at_term) begin
                        cnt_clear = 1'b1;
                        advance   = 1'b1;
                        state_n   = SEQ_RUN;
                    end
                end
                default: begin
                    state_n   = SEQ_IDLE;
                    cnt_clear = 1'b1;
                end
            endcase
        end

        sel_n    = pattern_sel_out;
        colour_n = colour_out;
        if (advance) begin
            if (pattern_sel_out == LAST_SEL) begin
                sel_n    = '0;
                colour_n = next_colour(colour_out);
            end else begin
                sel_n = pattern_sel_out + SEL_W'(1);
            end
        end

        // Restart is registered so it lines up with the new select.
        restart_n = (advance | start) ? (FIRST_ONE << sel_n) : '0;

        row_n = (state == SEQ_RUN && enable_in) ? pattern_rows_in[pattern_sel_out] : '0;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state               <= SEQ_IDLE;
            pattern_sel_out     <= '0;
            colour_out          <= 3'b001;
            pattern_restart_out <= '0;
            row_out             <= '0;
        end else begin
            state               <= state_n;
            pattern_sel_out     <= sel_n;
            colour_out          <= colour_n;
            pattern_restart_out <= restart_n;
            row_out             <= row_n;
        end
    end

endmodule
